// File: rtl/inv_matvec_apply_if.sv
// Stream interface for inv_matvec_apply: matrix/vector words in, solution words out.
// The master side is the producer/consumer around the block; the slave side is the block itself.
interface inv_matvec_apply_if #(
  parameter int DW = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_ovf;
  logic                 busy;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_ovf,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_ovf,
    output busy
  );
endinterface

// File: rtl/inv_matvec_apply.sv
// inv_matvec_apply: loads an NxN inverse matrix (row-major) and an N-vector b as one
// input stream, computes x = Ainv * b with one signed MAC per cycle, and streams the N
// saturated fixed-point results out under valid/ready flow control.
module inv_matvec_apply #(
  parameter int N    = 5,
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int AW   = 2*DW+3
) (
  input  logic              clk,
  input  logic              rst,
  inv_matvec_apply_if.slave io_if
);

  localparam int NN = N*N;
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_LOAD_M,
    S_LOAD_V,
    S_COMPUTE,
    S_OUTPUT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Shared element index: flat M index while loading M, b index while loading b,
  // flat M index again while computing.
  logic [IW-1:0] r_lidx;
  logic [CW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [CW-1:0] r_oidx;

  logic signed [AW-1:0] r_acc;

  logic signed [DW-1:0] r_m   [NN];
  logic signed [DW-1:0] r_b   [N];
  logic signed [DW-1:0] r_res [N];
  logic        [N-1:0]  r_ovf;

  logic                 r_in_ready;
  logic                 r_out_valid;
  logic signed [DW-1:0] r_out_data;
  logic                 r_out_ovf;
  logic                 r_busy;

  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_m_last;
  logic                  w_v_last;
  logic                  w_col_last;
  logic                  w_o_last;
  logic [CW-1:0]         w_oidx_nxt;
  logic signed [2*DW-1:0] w_prod;
  logic signed [AW-1:0]  w_prod_ext;
  logic signed [AW-1:0]  w_sum;
  logic signed [AW-1:0]  w_shift;
  logic [AW-DW:0]        w_hi;
  logic signed [DW-1:0]  w_sat_val;
  logic                  w_sat_ovf;

  assign w_in_fire  = io_if.in_valid && r_in_ready;
  assign w_out_fire = r_out_valid && io_if.out_ready;
  assign w_m_last   = (r_lidx == IW'(NN-1));
  assign w_v_last   = (r_lidx == IW'(N-1));
  assign w_col_last = (r_col  == CW'(N-1));
  assign w_o_last   = (r_oidx == CW'(N-1));
  assign w_oidx_nxt = r_oidx + 1'b1;

  // MAC datapath: full-width signed product, sign-extended into the accumulator width.
  assign w_prod     = r_m[r_lidx] * r_b[r_col];
  assign w_prod_ext = {{(AW-2*DW){w_prod[2*DW-1]}}, w_prod};
  assign w_sum      = r_acc + w_prod_ext;
  // Arithmetic shift drops the fraction bits, rounding toward -inf.
  assign w_shift    = w_sum >>> FRAC;
  // The value fits in DW bits only if every bit from DW-1 upward equals the sign.
  assign w_hi       = w_shift[AW-1:DW-1];

  // Saturate the scaled row sum to the signed DW range and flag when clipping occurred.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_sat_ovf = !((&w_hi) || !(|w_hi));
    w_sat_val = w_shift[DW-1:0];
    if (w_sat_ovf) begin
      w_sat_val = w_shift[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end

  // Next-state logic for the load / compute / output sequence.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_LOAD_M:  if (w_in_fire && w_m_last) w_state_nxt = S_LOAD_V;
      S_LOAD_V:  if (w_in_fire && w_v_last) w_state_nxt = S_COMPUTE;
      S_COMPUTE: if (w_m_last)              w_state_nxt = S_OUTPUT;
      S_OUTPUT:  if (w_out_fire && w_o_last) w_state_nxt = S_LOAD_M;
      default:   w_state_nxt = S_LOAD_M;
    endcase
  end

  // State register; reset aborts any solve in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOAD_M;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      r_state <= w_state_nxt;
    end
  end

  // Matrix and vector storage written by the input stream.
  // NOTE: this storage has no reset; every entry is rewritten by the load phase
  // before the compute phase reads it, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      if (r_state == S_LOAD_M) begin
        r_m[r_lidx] <= io_if.in_data;
      end else if (r_state == S_LOAD_V) begin
        r_b[r_lidx[CW-1:0]] <= io_if.in_data;
      end
    end
  end

  // Counters, accumulator, result buffer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lidx      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_oidx      <= '0;
      r_acc       <= '0;
      r_ovf       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
      r_busy      <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_res[i] <= '0;
      end
    end else begin
      r_in_ready <= (w_state_nxt == S_LOAD_M) || (w_state_nxt == S_LOAD_V);
      r_busy     <= (w_state_nxt == S_COMPUTE) || (w_state_nxt == S_OUTPUT);

      case (r_state)
        S_LOAD_M: begin
          if (w_in_fire) begin
            r_lidx <= w_m_last ? '0 : r_lidx + 1'b1;
          end
        end

        S_LOAD_V: begin
          if (w_in_fire) begin
            r_lidx <= w_v_last ? '0 : r_lidx + 1'b1;
          end
        end

        S_COMPUTE: begin
          r_lidx <= w_m_last ? '0 : r_lidx + 1'b1;
          if (w_col_last) begin
            // Row complete: scale, saturate, store and start the next row from zero.
            r_res[r_row] <= w_sat_val;
            r_ovf[r_row] <= w_sat_ovf;
            r_acc        <= '0;
            r_col        <= '0;
            r_row        <= w_m_last ? '0 : r_row + 1'b1;
          end else begin
            r_acc <= w_sum;
            r_col <= r_col + 1'b1;
          end
        end

        S_OUTPUT: begin
          if (!r_out_valid) begin
            // First cycle in OUTPUT: present result[0].
            r_out_valid <= 1'b1;
            r_out_data  <= r_res[r_oidx];
            r_out_ovf   <= r_ovf[r_oidx];
          end else if (io_if.out_ready) begin
            if (w_o_last) begin
              r_out_valid <= 1'b0;
              r_out_data  <= '0;
              r_out_ovf   <= 1'b0;
              r_oidx      <= '0;
            end else begin
              r_out_data  <= r_res[w_oidx_nxt];
              r_out_ovf   <= r_ovf[w_oidx_nxt];
              r_oidx      <= w_oidx_nxt;
            end
          end
        end

        default: ;
      endcase
    end
  end

  assign io_if.in_ready  = r_in_ready;
  assign io_if.out_valid = r_out_valid;
  assign io_if.out_data  = r_out_data;
  assign io_if.out_ovf   = r_out_ovf;
  assign io_if.busy      = r_busy;

endmodule
